// File: rtl/frodo_pkg.sv
// Shared constants and types for FrodoKEM matrix-A generation (AES variant).
// Holds the default dimensions, the AES block size and the controller state encoding.
package frodo_pkg;

    localparam int FRODO_N   = 640;
    localparam int FRODO_D   = 15;
    localparam int BLK_BYTES = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KS,
        S_KS_WAIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } gen_state_t;

    // Width of a counter that must hold every block index plus the total itself.
    function automatic int blk_idx_w(input int n);
        return $clog2(n * n / 8 + 1);
    endfunction

endpackage

// File: rtl/frodo_sync_fifo.sv
// Synchronous FIFO with show-ahead read data and an empty-bypass path.
// Latency: 0 cycles (push on empty is readable the same cycle); backpressure: caller gates push via count/full.
module frodo_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_vld,
    input  logic [WIDTH-1:0]         i_wr_dat,
    input  logic                     i_rd_rdy,
    output logic [WIDTH-1:0]         o_rd_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_bypass;
    logic             w_wr;
    logic             w_rd;

    assign o_count  = r_count;
    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    // A push into an empty FIFO that is popped in the same cycle never touches the memory.
    assign w_bypass = o_empty && i_wr_vld && i_rd_rdy;
    assign w_wr     = i_wr_vld && !w_bypass && (!o_full || i_rd_rdy);
    assign w_rd     = i_rd_rdy && !o_empty;
    assign o_rd_dat = o_empty ? i_wr_dat : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frodo_gen_a_aes.sv
// Drives the aes128 core for FrodoKEM matrix-A generation and unpacks ciphertexts into D-bit elements.
// Latency: AES latency + 1 cycle to first element; backpressure: i_elem_ready stalls output, credits stop issue.
module frodo_gen_a_aes
    import frodo_pkg::*;
#(
    parameter int N          = FRODO_N,
    parameter int D          = FRODO_D,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_seed_a,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [127:0] o_aes_key,
    output logic         o_aes_start_key_schedule,
    input  logic         i_aes_done_key_schedule,
    output logic [127:0] o_aes_data,
    output logic         o_aes_start,
    input  logic         i_aes_done,
    input  logic [127:0] i_aes_data,
    output logic [15:0]  o_elem,
    output logic         o_elem_valid,
    input  logic         i_elem_ready,
    output logic         o_elem_last
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int          BCW       = blk_idx_w(N);
    localparam int          TOTAL     = N * N / 8;
    localparam int          EPB       = BLK_BYTES / 2;
    localparam int          KW        = $clog2(EPB);
    localparam logic [15:0] ELEM_MASK = 16'((32'd1 << D) - 32'd1);

    gen_state_t     r_state;
    gen_state_t     w_state_nxt;
    logic [127:0]   r_key;
    logic           r_aes_start;
    logic [127:0]   r_aes_data;
    logic [15:0]    r_row;
    logic [15:0]    r_col;
    logic [CW-1:0]  r_inflight;
    logic           r_err;
    logic           r_ser_vld;
    logic [127:0]   r_ser_dat;
    logic [KW-1:0]  r_k;
    logic [BCW-1:0] r_out_blk;

    logic [127:0]   w_fifo_rd_dat;
    logic [CW-1:0]  w_fifo_count;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic           w_issue;
    logic           w_last_blk;
    logic           w_hs;
    logic           w_blk_end;
    logic           w_drain_done;
    logic [127:0]   w_shifted;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_push       = i_aes_done && (r_inflight != '0);
    // Credits cover both in-flight blocks and FIFO occupancy, so a push can never find the FIFO full.
    assign w_issue      = (r_state == S_STREAM) && !w_fifo_full &&
                          (({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign w_last_blk   = (r_row == 16'(N - 1)) && (r_col == 16'(N - 8));
    assign w_hs         = r_ser_vld && i_elem_ready;
    assign w_blk_end    = w_hs && (r_k == KW'(EPB - 1));
    assign w_pop        = (!w_fifo_empty || w_push) && (!r_ser_vld || w_blk_end);
    assign w_drain_done = (r_inflight == '0) && w_fifo_empty && !r_ser_vld;

    frodo_sync_fifo #(
        .WIDTH (128),
        .DEPTH (FIFO_DEPTH)
    ) u_ct_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr_vld (w_push),
        .i_wr_dat (i_aes_data),
        .i_rd_rdy (w_pop),
        .o_rd_dat (w_fifo_rd_dat),
        .o_count  (w_fifo_count),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_KS;
            S_KS:      w_state_nxt = S_KS_WAIT;
            S_KS_WAIT: if (i_aes_done_key_schedule) w_state_nxt = S_STREAM;
            S_STREAM:  if (w_issue && w_last_blk) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_drain_done) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key       <= '0;
            r_aes_start <= 1'b0;
            r_aes_data  <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_inflight  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_aes_start <= w_issue;
            if (w_accept) begin
                r_key <= i_seed_a;
                r_row <= '0;
                r_col <= '0;
            end
            if (w_issue) begin
                r_aes_data <= {r_row[7:0], r_row[15:8], r_col[7:0], r_col[15:8], 96'h0};
                if (r_col == 16'(N - 8)) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd8;
                end
            end
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (i_aes_done && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Serializer: reloads on the final element's handshake so consecutive blocks stream without a gap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ser_vld <= 1'b0;
            r_ser_dat <= '0;
            r_k       <= '0;
            r_out_blk <= '0;
        end else begin
            if (w_accept) begin
                r_out_blk <= '0;
            end
            if (w_pop) begin
                r_ser_vld <= 1'b1;
                r_ser_dat <= w_fifo_rd_dat;
                r_k       <= '0;
                r_out_blk <= r_out_blk + 1'b1;
            end else if (w_blk_end) begin
                r_ser_vld <= 1'b0;
            end else if (w_hs) begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign w_shifted    = r_ser_dat << {r_k, 4'b0000};
    assign o_elem       = {w_shifted[119:112], w_shifted[127:120]} & ELEM_MASK;
    assign o_elem_valid = r_ser_vld;
    assign o_elem_last  = r_ser_vld && (r_k == KW'(EPB - 1)) && (r_out_blk == BCW'(TOTAL));

    assign o_busy                   = (r_state == S_KS) || (r_state == S_KS_WAIT) ||
                                      (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign o_done                   = (r_state == S_DONE);
    assign o_err                    = r_err;
    assign o_aes_key                = r_key;
    assign o_aes_start_key_schedule = (r_state == S_KS);
    assign o_aes_data               = r_aes_data;
    assign o_aes_start              = r_aes_start;

endmodule

// File: tb/tb_frodo_gen_a_aes.sv
// Directed bench for frodo_gen_a_aes with a latency-11 pipelined AES stand-in and an element scoreboard.
`timescale 1ns/1ps
module tb_frodo_gen_a_aes;

    localparam int N      = 16;
    localparam int D      = 15;
    localparam int FD     = 4;
    localparam int LAT    = 11;
    localparam int KS_LAT = 5;
    localparam int TOTAL  = N * N / 8;
    localparam logic [127:0] CONST_CT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEED1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEED2    = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] SEED3    = 128'h5a5a5a5a0f0f0f0fa5a5a5a5f0f0f0f0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [127:0] seed = '0;
    logic         aes_done_ks = 1'b0;
    logic         aes_done = 1'b0;
    logic [127:0] aes_dout = '0;
    logic         elem_ready = 1'b0;

    logic         o_busy, o_done, o_err, o_aes_start_key_schedule, o_aes_start;
    logic [127:0] o_aes_key, o_aes_data;
    logic [15:0]  o_elem;
    logic         o_elem_valid, o_elem_last;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           aes_mode = 0;
    logic         spur_req = 1'b0;
    int           ks_cnt = 0;
    int           ks_due = -1;
    logic [127:0] ks_key = '0;
    int           done_cnt = 0;
    logic [127:0] issued[$];
    logic [127:0] pend_ct[$];
    int           pend_due[$];
    logic [16:0]  exp_q[$];

    always #5 clk = ~clk;

    frodo_gen_a_aes #(.N(N), .D(D), .FIFO_DEPTH(FD)) dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_start                  (start),
        .i_seed_a                 (seed),
        .o_busy                   (o_busy),
        .o_done                   (o_done),
        .o_err                    (o_err),
        .o_aes_key                (o_aes_key),
        .o_aes_start_key_schedule (o_aes_start_key_schedule),
        .i_aes_done_key_schedule  (aes_done_ks),
        .o_aes_data               (o_aes_data),
        .o_aes_start              (o_aes_start),
        .i_aes_done               (aes_done),
        .i_aes_data               (aes_dout),
        .o_elem                   (o_elem),
        .o_elem_valid             (o_elem_valid),
        .i_elem_ready             (elem_ready),
        .o_elem_last              (o_elem_last)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Input block for row i, column j: bytes 0..3 are i low, i high, j low, j high.
    function automatic logic [127:0] blk_model(input int i, input int j);
        return (128'(i % 256) << 120) | (128'(i / 256) << 112) |
               (128'(j % 256) << 104) | (128'(j / 256) << 96);
    endfunction

    function automatic logic [127:0] cipher(input logic [127:0] key, input logic [127:0] data, input int mode);
        logic [127:0] x;
        if (mode == 0) return CONST_CT;
        x = data ^ key;
        return {x[95:0], x[127:96]} + {4{x[127:96] * 32'h01000193}};
    endfunction

    // Element k takes ciphertext bytes 2k (low) and 2k+1 (high), reduced mod 2^d.
    function automatic logic [15:0] elem_model(input logic [127:0] ct, input int k, input int d);
        int lo, hi;
        lo = int'((ct >> (8 * (15 - 2 * k))) & 128'hff);
        hi = int'((ct >> (8 * (14 - 2 * k))) & 128'hff);
        return 16'((hi * 256 + lo) % (1 << d));
    endfunction

    task automatic load_expect(input logic [127:0] key, input int mode);
        logic [127:0] c;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j += 8) begin
                c = cipher(key, blk_model(i, j), mode);
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back({(i == N - 1) && (j == N - 8) && (k == 7), elem_model(c, k, D)});
                end
            end
        end
    endtask

    // AES stand-in: pipelined, fixed latency, shares the reset.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            pend_ct.delete();
            pend_due.delete();
            issued.delete();
            aes_done    = 1'b0;
            aes_done_ks = 1'b0;
            ks_due      = -1;
        end else begin
            aes_done_ks = (cyc == ks_due);
            if (o_aes_start_key_schedule) begin
                ks_cnt++;
                ks_key = o_aes_key;
                ks_due = cyc + KS_LAT;
            end
            if (o_aes_start) begin
                issued.push_back(o_aes_data);
                pend_ct.push_back(cipher(o_aes_key, o_aes_data, aes_mode));
                pend_due.push_back(cyc + LAT);
            end
            aes_done = 1'b0;
            if (spur_req) begin
                aes_done = 1'b1;
                aes_dout = CONST_CT;
                spur_req = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                aes_done = 1'b1;
                aes_dout = pend_ct.pop_front();
                void'(pend_due.pop_front());
            end
        end
    end

    // Output scoreboard and stall-stability monitor.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_elem;
        logic [16:0] e;
        prev_stall = 1'b0;
        prev_elem  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (o_done) begin
                    done_cnt++;
                    check("busy_low_with_done", 128'(o_busy), 128'd0);
                end
                if (prev_stall) check("hold_while_stalled", {o_elem_valid, o_elem}, {1'b1, prev_elem});
                prev_stall = o_elem_valid && !elem_ready;
                prev_elem  = o_elem;
                if (o_elem_valid && elem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_elem: got %h expected none", o_elem);
                    end else begin
                        e = exp_q.pop_front();
                        check("elem", 128'(o_elem), 128'(e[15:0]));
                        check("elem_last", 128'(o_elem_last), 128'(e[16]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [127:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // pattern 0: ready always high; pattern 1: ready low every third cycle.
    task automatic run_until_done(input int pattern, input string name);
        int n;
        n = 0;
        while (done_cnt < 1 && n < 4000) begin
            elem_ready = (pattern == 0) ? 1'b1 : (n % 3 != 2);
            tick();
            n++;
        end
        if (done_cnt < 1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no o_done expected o_done within 4000 cycles", name);
        end
        elem_ready = 1'b1;
        repeat (5) tick();
        check({name, "_done_once"}, 128'(done_cnt), 128'd1);
        check({name, "_all_elems"}, 128'(exp_q.size()), 128'd0);
        check({name, "_block_count"}, 128'(issued.size()), 128'(TOTAL));
        for (int b = 0; b < issued.size() && b < TOTAL; b++) begin
            check({name, "_block"}, issued[b], blk_model(b / (N / 8), (b % (N / 8)) * 8));
        end
    endtask

    initial begin
        logic [127:0] blk;
        int           t;
        int           seen;

        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_key", o_aes_key, 128'd0);
        check("reset_aes_data", o_aes_data, 128'd0);
        check("reset_ctrl", {o_busy, o_done, o_err, o_aes_start_key_schedule, o_aes_start,
                             o_elem, o_elem_valid, o_elem_last}, 128'd0);
        rst_n = 1'b1;
        tick();

        blk = blk_model(16'h0123, 16'h0208);
        check("pin_block_0123_0208", 128'(blk[127:96]), 128'h23010802);
        check("pin_block_0_8", blk_model(0, 8), 128'h00000800 << 96);
        check("pin_block_1_0", blk_model(1, 0), 128'h01000000 << 96);
        check("pin_elem0_d15", 128'(elem_model(CONST_CT, 0, 15)), 128'h1100);
        check("pin_elem4_d15", 128'(elem_model(CONST_CT, 4, 15)), 128'h1988);
        check("pin_elem4_d16", 128'(elem_model(CONST_CT, 4, 16)), 128'h9988);
        check("pin_elem7_d15", 128'(elem_model(CONST_CT, 7, 15)), 128'h7fee);

        // Run 1: constant ciphertext, free-running sink, second start while busy.
        aes_mode   = 0;
        elem_ready = 1'b1;
        done_cnt   = 0;
        ks_cnt     = 0;
        issued.delete();
        load_expect(SEED1, 0);
        pulse_start(SEED1);
        t = 0;
        while (ks_cnt < 1 && t < 100) begin
            tick();
            t++;
        end
        check("ks_pulse_seen", 128'(ks_cnt), 128'd1);
        check("ks_key", ks_key, SEED1);
        check("busy_during_run", 128'(o_busy), 128'd1);
        pulse_start(SEED2);
        run_until_done(0, "run1");
        check("run1_first_block", issued[0], 128'd0);
        check("run1_second_block", issued[1], 128'h00000800 << 96);
        check("run1_third_block", issued[2], 128'h01000000 << 96);
        check("run1_key_kept", o_aes_key, SEED1);
        check("run1_single_ks", 128'(ks_cnt), 128'd1);
        check("run1_no_err", 128'(o_err), 128'd0);

        // Run 2: sink stalled for 200 cycles, then intermittent ready.
        aes_mode   = 1;
        elem_ready = 1'b0;
        done_cnt   = 0;
        issued.delete();
        load_expect(SEED2, 1);
        pulse_start(SEED2);
        repeat (200) tick();
        // Four credits in the FIFO plus the block already held by the serializer.
        check("stall_issue_count", 128'(issued.size()), 128'(FD + 1));
        check("stall_valid_held", 128'(o_elem_valid), 128'd1);
        run_until_done(1, "run2");
        check("run2_no_err", 128'(o_err), 128'd0);

        // Run 3: asynchronous reset mid-stream, then a clean restart.
        elem_ready = 1'b1;
        done_cnt   = 0;
        issued.delete();
        load_expect(SEED3, 1);
        pulse_start(SEED3);
        t = 0;
        while (issued.size() < 10 && t < 500) begin
            tick();
            t++;
        end
        check("reached_block_10", 128'(issued.size() >= 10), 128'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_key", o_aes_key, 128'd0);
        check("async_reset_ctrl", {o_busy, o_done, o_err, o_aes_start_key_schedule, o_aes_start,
                                   o_elem, o_elem_valid, o_elem_last}, 128'd0);
        check("async_reset_data", o_aes_data, 128'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        done_cnt = 0;
        issued.delete();
        load_expect(SEED3, 1);
        pulse_start(SEED3);
        run_until_done(0, "run3");

        // Spurious AES completion while idle.
        check("idle_no_err", 128'(o_err), 128'd0);
        spur_req = 1'b1;
        repeat (3) tick();
        check("spurious_err", 128'(o_err), 128'd1);
        seen = 0;
        repeat (10) begin
            tick();
            if (o_elem_valid) seen++;
        end
        check("spurious_not_pushed", 128'(seen), 128'd0);
        check("spurious_idle", 128'(o_busy), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
